rr_arbiter_4: RTL
=================

# rr_arbiter_4

Four-requester round-robin arbiter that shares a single downstream resource, such as the 4-to-2 encoded select path, between requesters 0-3. It grants one requester at a time and reports the winner both one-hot and as a 2-bit encoded index. The grant is held until the owner releases. Rotating priority guarantees that no requester with a continuously asserted request waits longer than three other grants.

## Interface
- MAX_HOLD, 15: maximum grant length in cycles when the timeout feature is compiled in; legal range 2-255.

- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req  input  4  request vector; bit i high = requester i wants the resource.
- done  input  1  current owner releases the resource; qualified only in GRANT.
- gnt  output  4  one-hot grant, registered; all zero when no grant is active.
- gnt_idx  output  2  encoded index of the granted requester, registered; holds its last value when gnt_valid=0.
- gnt_valid  output  1  high while a grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 when the timeout feature is compiled out.

## Operation
- Reset value of every output and internal register: state=IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0, priority pointer ptr=0, hold counter=0.
- Two states: IDLE and GRANT.
- **IDLE, no request:** if req==0, stay in IDLE with all grant outputs low.
- **IDLE, request present:** the winner is the first set bit of req in the search order ptr, ptr+1, ptr+2, ptr+3, taken mod 4.
  - Register gnt=onehot(winner), gnt_idx=winner and gnt_valid=1.
  - Go to GRANT.
- **GRANT, hold:** the owner keeps the grant while req[gnt_idx]=1 and done=0.
  - Changes on the other req bits are ignored.
  - No preemption.
- **GRANT, release:** a release occurs when done=1 or req[gnt_idx]=0 is sampled.
  - Next cycle: gnt=0, gnt_valid=0, ptr=gnt_idx+1 mod 4 (3 wraps to 0), state=IDLE.
  - gnt_idx retains the old owner.
- **done in IDLE:** ignored.
- **Simultaneous requests:** resolved by the pointer order only, never by a fixed bit order.
- **Reset mid-grant:** when rst_n=0 is sampled in any state, the next cycle shows all reset values; no release bookkeeping is performed and ptr returns to 0.

## Timing
- **Grant latency:** req sampled high at edge N while in IDLE gives gnt valid after edge N, i.e. one cycle.
- **Release latency:** a release sampled at edge E drops gnt after E.
- **Bubble cycle:** after a release the arbiter always spends exactly one cycle in IDLE before the next grant.
  - If another request is pending, the new grant appears after edge E+1.
- **Minimum grant length:** 1 cycle, when done is high in the first GRANT cycle.
- **Back-to-back service:** with all four requesters holding req and each releasing via a one-cycle done, grants rotate 0,1,2,3,0,... with one bubble cycle between grants.
- All outputs are driven directly from flops; there are no combinational paths from input to output.

## Configuration
- **Macro: ARB_TIMEOUT_EN**
- **Defined:**
  - An 8-bit hold counter clears on grant and increments each cycle in GRANT.
  - If no release has occurred by the MAX_HOLD-th GRANT cycle, the arbiter performs a forced release: the next cycle has gnt=0 and timeout=1 for exactly one cycle.
  - ptr advances exactly as for a normal release.
  - If done arrives in the same cycle as the limit, it counts as a normal release and timeout stays 0.
- **Undefined:** no counter is built, grants are unbounded, and timeout is tied to 0.

## Test plan
- **Single request:** reset, then req=4'b0100 → one cycle later gnt=4'b0100, gnt_idx=2'b10, gnt_valid=1. Pulse done → gnt=0 next cycle, and ptr=3 is observed via the next grant order.
- **Round-robin fairness:** req=4'b1111 held, owner pulses done after 2 cycles each → gnt_idx sequence is 0,1,2,3,0 with exactly one gnt_valid=0 cycle between grants.
- **Pointer wrap and priority:** after serving requester 3, apply req=4'b0101 simultaneously → requester 0 is granted, not 2. Then after serving 0, apply req=4'b0101 again → requester 2 is granted.
- **Request withdrawal and done in IDLE:**
  - Owner 1 drops req[1] without done → release next cycle.
  - done pulses while in IDLE → no state change, outputs stay 0.
- **Reset mid-grant:** grant held by requester 2 and rst_n=0 for one edge → gnt=0, gnt_idx=0, gnt_valid=0. With req=4'b1111 after reset, requester 0 is granted first.
- **Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4):**
  - req[1] held, done never asserted → gnt=4'b0010 for exactly 4 cycles, then gnt=0 and timeout=1 for one cycle. req=4'b0010 is still held, so requester 1 is granted again after the bubble.
  - done asserted on cycle 4 → timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with hold-until-release
// grants, a registered one-hot grant, and a registered encoded grant index.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined: an 8-bit hold counter forces a release after MAX_HOLD cycles.
//   Undefined: grants are unbounded and timeout is tied to 0.
//
// Parameters:
//   MAX_HOLD   grant length limit in cycles when the timeout is built (2-255)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req[3:0]   request vector, bit i = requester i
//   done       owner releases the resource (only honoured while granting)
//   gnt[3:0]   registered one-hot grant, zero when idle
//   gnt_idx    registered index of the owner, holds its value when idle
//   gnt_valid  registered, high while a grant is active (== |gnt)
//   timeout    one-cycle pulse after a forced release
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] ptr;
  logic [1:0] ptr_nx;
  logic [3:0] gnt_nx;
  logic [1:0] idx_nx;
  logic       valid_nx;
  logic       tout_nx;

  logic       win_any;
  logic [1:0] win;
  logic [1:0] cand;
  logic       rel;
  logic       limit;

  // Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). Scanning the
  // offsets from far to near lets the nearest set bit overwrite the rest.
  always_comb begin
    win_any = 1'b0;
    win     = ptr;
    cand    = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        win_any = 1'b1;
        win     = cand;
      end
    end
  end

  // Owner gives the resource back either explicitly or by dropping req.
  assign rel = done || !req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic [7:0] hold_nx;

  // hold_cnt is 0 in the first GRANT cycle, so MAX_HOLD-1 marks the
  // last cycle a grant may be held.
  assign limit = (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign limit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gnt_nx   = gnt;
    idx_nx   = gnt_idx;
    valid_nx = gnt_valid;
    tout_nx  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_nx  = hold_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (win_any) begin
          state_nx = GRANT;
          gnt_nx   = 4'b0001 << win;
          idx_nx   = win;
          valid_nx = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_nx  = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (rel || limit) begin
          state_nx = IDLE;
          gnt_nx   = 4'b0000;
          valid_nx = 1'b0;
          ptr_nx   = gnt_idx + 2'd1;
          // A done that lands on the limit cycle is a normal release.
          tout_nx  = !rel;
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_nx = hold_cnt + 8'd1;
`endif
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= idx_nx;
      gnt_valid <= valid_nx;
      timeout   <= tout_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_nx;
    end
  end
`endif

endmodule
